apb_cmd_master: RTL

- Single-outstanding APB master that turns a valid/ready request from the core side into a compliant APB SETUP/ACCESS transfer.
- Sits directly upstream of the APB SPI master and drives its PADDR/PWDATA/PWRITE/PSEL/PENABLE.
- Returns read data and slave error to the requester over a valid/ready response channel.

---
 rtl/apb_cmd_master_if.sv | 37 +++
 rtl/apb_cmd_master.sv | 97 +++++++++
 2 files changed

// File: rtl/apb_cmd_master_if.sv
// Core-side request/response channels plus the APB master bus of apb_cmd_master.
// master modport is the DUT view; slave modport is the requester/APB-slave view.
interface apb_cmd_master_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]               req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: one request -> SETUP/ACCESS -> one response; all outputs registered.
// Optional ACCESS wait timeout enabled by defining APB_CMD_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  apb_cmd_master_if.master  bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   complete;
  logic   timeout;

  assign accept = (state == IDLE) && bus.req_valid;

`ifdef APB_CMD_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt;

  // Cleared while in SETUP so it starts at 0 on the first ACCESS cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !bus.PREADY) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign timeout = (state == ACCESS) && !bus.PREADY && (wait_cnt == TO_LIM);
`else
  assign timeout = 1'b0;
`endif

  assign complete = (state == ACCESS) && (bus.PREADY || timeout);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = SETUP;
      SETUP:                      state_nxt = ACCESS;
      ACCESS:  if (complete)      state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake/strobe outputs are the decoded next state, so they line up with the state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.PWRITE    <= 1'b0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
    end else begin
      bus.req_ready <= (state_nxt == IDLE);
      bus.PSEL      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      bus.PENABLE   <= (state_nxt == ACCESS);
      bus.rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        bus.PADDR  <= bus.req_addr;
        bus.PWRITE <= bus.req_write;
        bus.PWDATA <= bus.req_write ? bus.req_wdata : 32'h0;
      end
      // PADDR/PWRITE are deliberately retained after completion; only PWDATA is cleared.
      if (complete) begin
        bus.PWDATA    <= 32'h0;
        bus.rsp_rdata <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : 32'h0;
        bus.rsp_err   <= bus.PREADY ? bus.PSLVERR : 1'b1;
      end
    end
  end

endmodule
